// File: rtl/temp_sample_scheduler.sv
// Periodic temperature sampler: averages 2^AVG_LOG2 good sensor reads, retries failures, latches a fault.
// Optional build macro FAN_FAILSAFE_EN: entering FAULT publishes 8'hFF so the fan runs flat out.
module temp_sample_scheduler #(
    parameter int SAMPLE_PERIOD = 50000000,
    parameter int TIMEOUT_CYC   = 1000000,
    parameter int AVG_LOG2      = 2,
    parameter int MAX_RETRY     = 3,
    parameter int TEMP_MAX      = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    output logic       sens_start,
    input  logic       sens_done,
    input  logic       sens_err,
    input  logic [7:0] sens_data,
    output logic [7:0] temp,
    output logic       temp_valid,
    output logic       sensor_fault
);

    localparam int PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam int SW = AVG_LOG2 + 1;
    localparam int AW = 8 + AVG_LOG2;

    localparam logic [PW-1:0] PERIOD_LAST = PW'(SAMPLE_PERIOD - 1);
    localparam logic [TW-1:0] TIMEOUT_LIM = TW'(TIMEOUT_CYC);
    localparam logic [RW-1:0] RETRY_LIM   = RW'(MAX_RETRY);
    localparam logic [SW-1:0] SAMPLES     = SW'(1 << AVG_LOG2);
    localparam logic [7:0]    TEMP_LIM    = 8'(TEMP_MAX);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_DONE,
        PUBLISH,
        FAULT
    } state_t;

    state_t        state_reg, state_next;
    logic [PW-1:0] period_reg;
    logic [TW-1:0] timeout_reg;
    logic [RW-1:0] retry_reg;
    logic [SW-1:0] sample_reg;
    logic [AW-1:0] acc_reg;
    logic [7:0]    temp_reg;
    logic          temp_valid_reg;

    logic          tick;
    logic          sample_ok;
    logic          timeout_hit;
    logic [RW-1:0] retry_inc;
    logic [SW-1:0] sample_inc;
    logic [AW-1:0] acc_sum;
    logic          good;
    logic          fail;
    logic          last_sample;
    logic          give_up;

    assign tick        = enable && (period_reg == PERIOD_LAST);
    assign sample_ok   = !sens_err && (sens_data <= TEMP_LIM);
    assign timeout_hit = (timeout_reg + TW'(1)) == TIMEOUT_LIM;
    assign retry_inc   = retry_reg + RW'(1);
    assign sample_inc  = sample_reg + SW'(1);
    assign acc_sum     = acc_reg + AW'(sens_data);
    assign last_sample = (sample_inc == SAMPLES);
    assign give_up     = (retry_inc > RETRY_LIM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // sens_done in the same cycle as the timeout is treated as a real response.
    always_comb begin
        state_next = state_reg;
        good       = 1'b0;
        fail       = 1'b0;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (tick) begin
                        state_next = START;
                    end
                end
                START: begin
                    state_next = WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (sens_done) begin
                        if (sample_ok) begin
                            good       = 1'b1;
                            state_next = last_sample ? PUBLISH : IDLE;
                        end else begin
                            fail = 1'b1;
                        end
                    end else if (timeout_hit) begin
                        fail = 1'b1;
                    end
                    if (fail) begin
                        state_next = give_up ? FAULT : START;
                    end
                end
                PUBLISH: begin
                    state_next = IDLE;
                end
                FAULT: begin
                    state_next = FAULT;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_reg <= '0;
        end else if (!enable || tick) begin
            period_reg <= '0;
        end else begin
            period_reg <= period_reg + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_reg <= '0;
            retry_reg   <= '0;
        end else if (!enable) begin
            timeout_reg <= '0;
            retry_reg   <= '0;
        end else begin
            if (state_reg == START) begin
                timeout_reg <= '0;
            end else if (state_reg == WAIT_DONE) begin
                timeout_reg <= timeout_reg + TW'(1);
            end
            if (good) begin
                retry_reg <= '0;
            end else if (fail) begin
                retry_reg <= retry_inc;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_reg <= '0;
            acc_reg    <= '0;
        end else if (!enable || state_reg == PUBLISH) begin
            sample_reg <= '0;
            acc_reg    <= '0;
        end else if (good) begin
            sample_reg <= sample_inc;
            acc_reg    <= acc_sum;
        end
    end

    // The average is registered on the final good sample so it is visible during PUBLISH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            temp_reg       <= '0;
            temp_valid_reg <= 1'b0;
        end else begin
            temp_valid_reg <= 1'b0;
            if (good && last_sample) begin
                temp_reg       <= acc_sum[AW-1:AVG_LOG2];
                temp_valid_reg <= 1'b1;
            end
`ifdef FAN_FAILSAFE_EN
            if (fail && give_up) begin
                temp_reg       <= 8'hFF;
                temp_valid_reg <= 1'b1;
            end
`endif
        end
    end

    assign sens_start   = (state_reg == START) && enable;
    assign sensor_fault = (state_reg == FAULT);
    assign temp         = temp_reg;
    assign temp_valid   = temp_valid_reg;

endmodule

// File: tb/tb_temp_sample_scheduler.sv
// Directed bench for temp_sample_scheduler: table of sensor responses plus hand sequences
// for fault latching, enable drop and asynchronous reset.
module tb_temp_sample_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       sens_start;
    logic       sens_done;
    logic       sens_err;
    logic [7:0] sens_data;
    logic [7:0] temp;
    logic       temp_valid;
    logic       sensor_fault;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_start = 0;

`ifdef FAN_FAILSAFE_EN
    localparam int HELD = 255;
    localparam int FS_V = 1;
`else
    localparam int HELD = 25;
    localparam int FS_V = 0;
`endif

    temp_sample_scheduler #(
        .SAMPLE_PERIOD(16),
        .TIMEOUT_CYC(8),
        .AVG_LOG2(2),
        .MAX_RETRY(2),
        .TEMP_MAX(100)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .sens_start(sens_start),
        .sens_done(sens_done),
        .sens_err(sens_err),
        .sens_data(sens_data),
        .temp(temp),
        .temp_valid(temp_valid),
        .sensor_fault(sensor_fault)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int resp;
        int err;
        int data;
        int gap;
        int exp_valid;
        int exp_temp;
        int exp_start;
        int exp_fault;
    } vec_t;

    vec_t tbl[24];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_start(output int s);
        int found = 0;
        for (int i = 0; i < 40; i++) begin
            if (sens_start) begin
                found = 1;
                break;
            end
            step();
        end
        chk("start_seen", found, 1);
        s = cyc;
    endtask

    task automatic run_entry(input int idx);
        vec_t v;
        int   s;
        v = tbl[idx];
        wait_start(s);
        if (v.gap != 0) chk($sformatf("gap[%0d]", idx), s - last_start, v.gap);
        last_start = s;
        if (v.resp != 0) begin
            step();
            sens_done = 1'b1;
            sens_err  = v.err[0];
            sens_data = 8'(v.data);
            step();
            sens_done = 1'b0;
            sens_err  = 1'b0;
            sens_data = 8'd0;
        end else begin
            repeat (9) step();
        end
        chk($sformatf("valid[%0d]", idx), int'(temp_valid), v.exp_valid);
        chk($sformatf("temp[%0d]", idx), int'(temp), v.exp_temp);
        chk($sformatf("start[%0d]", idx), int'(sens_start), v.exp_start);
        chk($sformatf("fault[%0d]", idx), int'(sensor_fault), v.exp_fault);
        $display("entry %0d: resp=%0d err=%0d data=%0d start@%0d temp=%0d valid=%0d fault=%0d",
                 idx, v.resp, v.err, v.data, s, temp, temp_valid, sensor_fault);
        if (v.exp_valid != 0) begin
            step();
            chk($sformatf("valid_pulse[%0d]", idx), int'(temp_valid), 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int any_start;
        int fault_low;
        int s;

        // resp err data gap valid temp start fault
        tbl[0]  = '{1, 0, 20,  0,  0,    0,    0, 0};
        tbl[1]  = '{1, 0, 22,  16, 0,    0,    0, 0};
        tbl[2]  = '{1, 0, 24,  16, 0,    0,    0, 0};
        tbl[3]  = '{1, 0, 26,  16, 1,    23,   0, 0};
        tbl[4]  = '{1, 0, 25,  16, 0,    23,   0, 0};
        tbl[5]  = '{1, 1, 25,  16, 0,    23,   1, 0};
        tbl[6]  = '{1, 0, 25,  2,  0,    23,   0, 0};
        tbl[7]  = '{1, 0, 150, 14, 0,    23,   1, 0};
        tbl[8]  = '{1, 0, 25,  2,  0,    23,   0, 0};
        tbl[9]  = '{1, 0, 26,  14, 1,    25,   0, 0};
        tbl[10] = '{0, 0, 0,   16, 0,    25,   1, 0};
        tbl[11] = '{0, 0, 0,   9,  0,    25,   1, 0};
        tbl[12] = '{0, 0, 0,   9,  FS_V, HELD, 0, 1};
        tbl[13] = '{1, 0, 30,  0,  0,    HELD, 0, 0};
        tbl[14] = '{1, 0, 32,  16, 0,    HELD, 0, 0};
        tbl[15] = '{1, 0, 10,  0,  0,    HELD, 0, 0};
        tbl[16] = '{1, 0, 10,  16, 0,    HELD, 0, 0};
        tbl[17] = '{1, 0, 10,  16, 0,    HELD, 0, 0};
        tbl[18] = '{1, 0, 10,  16, 1,    10,   0, 0};
        tbl[19] = '{1, 0, 50,  16, 0,    10,   0, 0};
        tbl[20] = '{1, 0, 40,  0,  0,    0,    0, 0};
        tbl[21] = '{1, 0, 40,  16, 0,    0,    0, 0};
        tbl[22] = '{1, 0, 40,  16, 0,    0,    0, 0};
        tbl[23] = '{1, 0, 44,  16, 1,    41,   0, 0};

        rst       = 1'b1;
        enable    = 1'b0;
        sens_done = 1'b0;
        sens_err  = 1'b0;
        sens_data = 8'd0;
        repeat (3) step();
        chk("reset_start", int'(sens_start), 0);
        chk("reset_temp", int'(temp), 0);
        chk("reset_valid", int'(temp_valid), 0);
        chk("reset_fault", int'(sensor_fault), 0);
        rst = 1'b0;
        step();
        enable = 1'b1;

        // averaging, truncation, error and out-of-range retries, timeouts into fault
        for (int i = 0; i <= 12; i++) run_entry(i);

        // fault is latched and silent until enable drops
        any_start = 0;
        fault_low = 0;
        repeat (30) begin
            step();
            if (sens_start) any_start = 1;
            if (!sensor_fault) fault_low = 1;
        end
        chk("fault_no_start", any_start, 0);
        chk("fault_held", fault_low, 0);
        $display("fault hold: no_start=%0d held=%0d", !any_start, !fault_low);
        enable = 1'b0;
        step();
        chk("fault_clear", int'(sensor_fault), 0);
        chk("fault_temp_kept", int'(temp), HELD);
        step();
        enable = 1'b1;

        // two good samples, then enable drop in WAIT_DONE with a late response
        for (int i = 13; i <= 14; i++) run_entry(i);
        wait_start(s);
        step();
        enable = 1'b0;
        step();
        sens_done = 1'b1;
        sens_data = 8'd40;
        step();
        sens_done = 1'b0;
        sens_data = 8'd0;
        chk("late_done_valid", int'(temp_valid), 0);
        chk("late_done_temp", int'(temp), HELD);
        any_start = 0;
        repeat (20) begin
            step();
            if (sens_start) any_start = 1;
        end
        chk("disabled_no_start", any_start, 0);
        $display("enable drop: late done ignored, temp=%0d", temp);
        enable = 1'b1;
        for (int i = 15; i <= 19; i++) run_entry(i);

        // asynchronous reset in the middle of WAIT_DONE
        wait_start(s);
        step();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_temp", int'(temp), 0);
        chk("arst_valid", int'(temp_valid), 0);
        chk("arst_start", int'(sens_start), 0);
        chk("arst_fault", int'(sensor_fault), 0);
        $display("async reset mid-wait: temp=%0d valid=%0d start=%0d fault=%0d",
                 temp, temp_valid, sens_start, sensor_fault);
        step();
        rst = 1'b0;
        step();
        for (int i = 20; i <= 23; i++) run_entry(i);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
